bus_cycle_sequencer: RTL and testbench

//  Sits upstream of the 2-to-4 chip-select decoder (ttl_74139). Accepts one CPU bus

---
 rtl/bus_cycle_sequencer_pkg.sv | 19 +
 rtl/bus_cycle_sequencer_if.sv | 33 +++
 rtl/bus_cycle_sequencer_wait_counter.sv | 28 ++
 rtl/bus_cycle_sequencer.sv | 125 ++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_cycle_sequencer_pkg.sv
// Shared types and constants for the bus cycle sequencer.
// Holds the FSM state encoding, the region codes and the wait-counter width.
package nine_e_bus_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        HOLD   = 2'b11
    } state_t;

    localparam logic [1:0] REG_RAM0 = 2'b00;
    localparam logic [1:0] REG_RAM1 = 2'b01;
    localparam logic [1:0] REG_ROM  = 2'b10;
    localparam logic [1:0] REG_IO   = 2'b11;

endpackage

// File: rtl/bus_cycle_sequencer_if.sv
// Request/response and device-bus signals of the bus cycle sequencer.
// The master side is the requester plus the device data path; the slave side is the sequencer.
interface bus_cycle_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_rw;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  rd_n;
    logic                  wr_n;
    logic [1:0]            dec_a;
    logic                  dec_en_n;

    modport master (
        output req_valid, req_addr, req_rw, req_wdata, bus_rdata,
        input  req_ready, resp_valid, resp_rdata, bus_addr, bus_wdata,
               rd_n, wr_n, dec_a, dec_en_n
    );

    modport slave (
        input  req_valid, req_addr, req_rw, req_wdata, bus_rdata,
        output req_ready, resp_valid, resp_rdata, bus_addr, bus_wdata,
               rd_n, wr_n, dec_a, dec_en_n
    );
endinterface

// File: rtl/bus_cycle_sequencer_wait_counter.sv
// Loadable down-counter that times the ACCESS phase.
// Stops at zero so a stray decrement can never wrap.
module wait_counter
    import nine_e_bus_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_value,
    input  logic              i_dec,
    output logic              o_zero
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Single-outstanding bus cycle sequencer in front of a 2-to-4 chip-select decoder.
// Runs SETUP / ACCESS (per-region wait states) / HOLD; every output is a flop.
module bus_cycle_sequencer
    import nine_e_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT0      = 0,
    parameter int WAIT1      = 0,
    parameter int WAIT2      = 1,
    parameter int WAIT3      = 3
) (
    input logic                  i_clk,
    input logic                  i_reset,
    bus_cycle_sequencer_if.slave bus
);

    localparam int WAIT_MAX = (1 << WAIT_W) - 1;

    if (WAIT0 < 0 || WAIT0 > WAIT_MAX || WAIT1 < 0 || WAIT1 > WAIT_MAX ||
        WAIT2 < 0 || WAIT2 > WAIT_MAX || WAIT3 < 0 || WAIT3 > WAIT_MAX) begin : g_wait_range
        $error("bus_cycle_sequencer: WAIT0..WAIT3 must lie in 0..15");
    end

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rw;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic                  r_rd_n;
    logic                  r_wr_n;
    logic                  r_dec_en_n;

    logic [1:0]            w_region;
    logic [WAIT_W-1:0]     w_wait;
    logic                  w_accept;
    logic                  w_zero;
    logic                  w_capture;

    assign w_region = r_addr[ADDR_WIDTH-1 -: 2];

    always_comb begin
        w_wait = '0;
        case (w_region)
            REG_RAM0: w_wait = WAIT_W'(WAIT0);
            REG_RAM1: w_wait = WAIT_W'(WAIT1);
            REG_ROM:  w_wait = WAIT_W'(WAIT2);
            REG_IO:   w_wait = WAIT_W'(WAIT3);
            default:  w_wait = '0;
        endcase
    end

    wait_counter u_wait_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (r_state == SETUP),
        .i_value (w_wait),
        .i_dec   (r_state == ACCESS),
        .o_zero  (w_zero)
    );

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = bus.req_valid && r_req_ready;
                if (w_accept) w_next = SETUP;
            end
            SETUP:  w_next = ACCESS;
            ACCESS: begin
                if (w_zero) begin
                    w_next    = HOLD;
                    w_capture = r_rw;
                end
            end
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the phase they describe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_rw         <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rd_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_dec_en_n   <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_rw    <= bus.req_rw;
            end
            if (w_capture) r_rdata <= bus.bus_rdata;
            r_req_ready  <= (w_next == IDLE);
            r_resp_valid <= (w_next == HOLD);
            r_dec_en_n   <= (w_next != ACCESS);
            r_rd_n       <= !((w_next == ACCESS) && r_rw);
            r_wr_n       <= !((w_next == ACCESS) && !r_rw);
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.bus_addr   = r_addr;
    assign bus.bus_wdata  = r_wdata;
    assign bus.rd_n       = r_rd_n;
    assign bus.wr_n       = r_wr_n;
    assign bus.dec_a      = w_region;
    assign bus.dec_en_n   = r_dec_en_n;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Bench for bus_cycle_sequencer: directed scenarios plus random traffic, every output
// compared each cycle against a timeline model of the accepted request.
module tb_bus_cycle_sequencer;
    import nine_e_bus_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int W0 = 0;
    localparam int W1 = 0;
    localparam int W2 = 1;
    localparam int W3 = 3;

    int waits [4] = '{W0, W1, W2, W3};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_cycle_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bus_cycle_sequencer #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
        .WAIT0 (W0), .WAIT1 (W1), .WAIT2 (W2), .WAIT3 (W3)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Timeline model: after accepting, k counts edges; SETUP at k=0, ACCESS for
    // k=1..1+W, HOLD at k=2+W, idle again at k=3+W.
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_k = 0;
    int          m_w = 0;
    logic [15:0] m_addr  = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_rdata = '0;
    logic        m_rw    = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_busy  = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
            m_rdata = '0;
            m_rw    = 1'b0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy  = 1'b1;
                m_k     = 0;
                m_addr  = bus.req_addr;
                m_wdata = bus.req_wdata;
                m_rw    = bus.req_rw;
                m_w     = waits[bus.req_addr[15:14]];
            end
        end else begin
            m_k++;
            if (m_k == 2 + m_w && m_rw) m_rdata = bus.bus_rdata;
            if (m_k == 3 + m_w) m_busy = 1'b0;
        end
    end

    bit         rdata_fixed = 1'b0;
    logic [7:0] rdata_val   = 8'h00;
    always @(negedge clk) bus.bus_rdata = rdata_fixed ? rdata_val : 8'($urandom);

    bit         in_acc;
    logic       prev_en_n  = 1'b1;
    logic [1:0] prev_dec_a = 2'b00;

    always @(negedge clk) begin
        in_acc = m_busy && (m_k >= 1) && (m_k <= 1 + m_w);
        check_val("req_ready",  32'(bus.req_ready),  32'(!m_busy));
        check_val("resp_valid", 32'(bus.resp_valid), 32'(m_busy && (m_k == 2 + m_w)));
        check_val("dec_en_n",   32'(bus.dec_en_n),   32'(!in_acc));
        check_val("rd_n",       32'(bus.rd_n),       32'(!(in_acc && m_rw)));
        check_val("wr_n",       32'(bus.wr_n),       32'(!(in_acc && !m_rw)));
        check_val("dec_a",      32'(bus.dec_a),      32'(m_addr[15:14]));
        check_val("bus_addr",   32'(bus.bus_addr),   32'(m_addr));
        check_val("bus_wdata",  32'(bus.bus_wdata),  32'(m_wdata));
        check_val("resp_rdata", 32'(bus.resp_rdata), 32'(m_rdata));
        if (!bus.dec_en_n && !prev_en_n) check_val("dec_a_stable", 32'(bus.dec_a), 32'(prev_dec_a));
        prev_en_n  = bus.dec_en_n;
        prev_dec_a = bus.dec_a;
    end

    task automatic wait_idle();
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("idle_wait", 32'(bus.req_ready), 32'd1);
    endtask

    // Presents a request, waits for the accepting edge, then scrambles the inputs.
    task automatic send(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                        input bit keep_valid, output int acc_cyc);
        int  n = 0;
        bit  rdy;
        bus.req_addr  = a;
        bus.req_rw    = rw;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        forever begin
            rdy = bus.req_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 40) begin
                check_val("accept_wait", 32'(bus.req_ready), 32'd1);
                break;
            end
        end
        acc_cyc       = cyc;
        bus.req_addr  = 16'($urandom);
        bus.req_rw    = 1'($urandom);
        bus.req_wdata = 8'($urandom);
        if (!keep_valid) bus.req_valid = 1'b0;
    endtask

    int t, t1, t2, t3, cnt, resp_at;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_rw    = 1'b0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Read from RAM region with a fixed read value
        rdata_fixed = 1'b1;
        rdata_val   = 8'hA5;
        send(16'h1234, 1'b1, 8'h00, 1'b0, t);
        resp_at = -1;
        for (int i = 0; i < 10; i++) begin
            if (bus.resp_valid && resp_at < 0) resp_at = cyc - t;
            @(negedge clk);
        end
        check_val("t1_resp_latency", 32'(resp_at), 32'(2 + W0));
        check_val("t1_resp_rdata", 32'(bus.resp_rdata), 32'h0000_00A5);
        rdata_fixed = 1'b0;

        // Write to I/O region: strobe width and untouched read data
        wait_idle();
        send(16'hC010, 1'b0, 8'h5A, 1'b0, t);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.wr_n) begin
                cnt++;
                check_val("t2_wdata", 32'(bus.bus_wdata), 32'h0000_005A);
            end
            @(negedge clk);
        end
        check_val("t2_wr_width", 32'(cnt), 32'(W3 + 1));
        check_val("t2_rdata_kept", 32'(bus.resp_rdata), 32'h0000_00A5);

        // ROM read: region code set up before the enable falls and held through HOLD
        wait_idle();
        send(16'h8000, 1'b1, 8'h00, 1'b0, t);
        check_val("t3_dec_a_setup", 32'(bus.dec_a), 32'(REG_ROM));
        check_val("t3_en_setup", 32'(bus.dec_en_n), 32'd1);
        cnt = 0;
        while (!bus.resp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_val("t3_dec_a_hold", 32'(bus.dec_a), 32'(REG_ROM));

        // Valid held across three requests: accept spacing follows each wait count
        wait_idle();
        send(16'h8ABC, 1'b1, 8'h00, 1'b1, t1);
        send(16'hC123, 1'b0, 8'h77, 1'b1, t2);
        send(16'h4321, 1'b1, 8'h00, 1'b0, t3);
        check_val("t4_spacing_rom", 32'(t2 - t1), 32'(4 + W2));
        check_val("t4_spacing_io",  32'(t3 - t2), 32'(4 + W3));

        // Reset in the second ACCESS cycle of an I/O read aborts it silently
        wait_idle();
        send(16'hC0F0, 1'b1, 8'h00, 1'b0, t);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("t5_rd_n",     32'(bus.rd_n),      32'd1);
        check_val("t5_en_n",     32'(bus.dec_en_n),  32'd1);
        check_val("t5_ready",    32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("t5_no_resp", 32'(bus.resp_valid), 32'd0);
        end

        // Random traffic; send() also changes the inputs right after every accept
        for (int i = 0; i < 200; i++) begin
            bus.req_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(16'($urandom), 1'($urandom), 8'($urandom), 1'b0, t);
        end
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
